// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer evaluator: one shared LUT memory, one lookup per
// neuron per cycle, results gathered into a vector and handed downstream.
module lut_layer_sequencer #(
  parameter int NEURONS  = 8,
  parameter int FAN_IN   = 8,
  parameter int OUT_BITS = 1,
  parameter int MEM_LAT  = 1,
  parameter int IDX_W    = $clog2(NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NEURONS*FAN_IN-1:0]    s_data,
  output logic                         mem_en,
  output logic [IDX_W+FAN_IN-1:0]      mem_addr,
  input  logic [OUT_BITS-1:0]          mem_rdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NEURONS*OUT_BITS-1:0]  m_data,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                        state;
  logic [NEURONS*FAN_IN-1:0]     frame;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_nxt;
  logic [MEM_LAT-1:0]            vld_p;
  logic [IDX_W-1:0]              idx_p [MEM_LAT];
  logic [NEURONS*OUT_BITS-1:0]   result;
  logic                          ret_last;

  function automatic logic [FAN_IN-1:0] slice_of(input logic [NEURONS*FAN_IN-1:0] f,
                                                 input logic [IDX_W-1:0] k);
    logic [FAN_IN-1:0] s;
    s = '0;
    for (int i = 0; i < NEURONS; i++)
      if (k == IDX_W'(i)) s = f[i*FAN_IN +: FAN_IN];
    return s;
  endfunction

  assign idx_nxt  = idx + IDX_W'(1);
  assign ret_last = vld_p[MEM_LAT-1] && (idx_p[MEM_LAT-1] == IDX_W'(NEURONS-1));
  assign m_data   = result;

  // s_ready is registered, so it re-arms one cycle after a transfer returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            s_ready  <= 1'b0;
            mem_en   <= 1'b1;
            mem_addr <= {IDX_W'(0), s_data[FAN_IN-1:0]};
            idx      <= '0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == IDX_W'(NEURONS-1)) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
            state    <= DRAIN;
          end else begin
            idx      <= idx_nxt;
            mem_addr <= {idx_nxt, slice_of(frame, idx_nxt)};
          end
        end
        DRAIN: begin
          if (ret_last) begin
            m_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && s_valid && s_ready) frame <= s_data;
  end

  // return pipeline p0..p(MEM_LAT-1): tag travels alongside the memory read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= mem_en;
      for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= idx;
    for (int i = 1; i < MEM_LAT; i++) idx_p[i] <= idx_p[i-1];
  end

  // result write-back at the pipeline exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      for (int k = 0; k < NEURONS; k++)
        if (vld_p[MEM_LAT-1] && idx_p[MEM_LAT-1] == IDX_W'(k))
          result[k*OUT_BITS +: OUT_BITS] <= mem_rdata;
    end
  end

endmodule

// File: doc/lut_layer_sequencer.md
# lut_layer_sequencer

Time-multiplexed evaluation controller for one LogicNets layer. The layer's truth tables sit in a single shared LUT memory, one 2^FAN_IN-entry table per neuron, instead of one distributed-ROM instance per neuron. The block accepts a gathered input frame over a valid/ready handshake and issues one lookup per neuron, one per cycle. It collects the OUT_BITS-wide results into an output vector and presents that vector downstream over a second valid/ready handshake. It sits between the layer's input gather wiring and the next layer.

## Interface
Parameters:
- NEURONS, 8, number of neurons sequenced per frame (≥2).
- FAN_IN, 8, input bits per neuron; width of each table index.
- OUT_BITS, 1, output bits per neuron.
- MEM_LAT, 1, fixed LUT memory read latency in cycles (1..4).
- IDX_W, clog2(NEURONS), derived neuron index width.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- s_valid  in  1  input frame valid.
- s_ready  out  1  block can accept a frame.
- s_data  in  NEURONS*FAN_IN  gathered frame; neuron k uses s_data[k*FAN_IN +: FAN_IN].
- mem_en  out  1  LUT memory read strobe.
- mem_addr  out  IDX_W+FAN_IN  read address {k, slice_k}.
- mem_rdata  in  OUT_BITS  read data, valid exactly MEM_LAT cycles after mem_en.
- m_valid  out  1  result vector valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  NEURONS*OUT_BITS  results; neuron k is at m_data[k*OUT_BITS +: OUT_BITS].
- busy  out  1  asserted whenever state ≠ IDLE.

## Operation
- Datapath registers:
  - frame register (NEURONS*FAN_IN).
  - issue index idx (IDX_W).
  - return pipeline: MEM_LAT stages of {valid, idx}.
  - result register (NEURONS*OUT_BITS).
- FSM states:
  - IDLE: s_ready=1. On s_valid, capture s_data, set idx=0, go to ISSUE.
  - ISSUE: mem_en=1, mem_addr={idx, frame[idx*FAN_IN +: FAN_IN]}, then idx++. When idx==NEURONS-1, go to DRAIN.
  - DRAIN: mem_en=0. When the return tag with idx==NEURONS-1 is written, go to OUT.
  - OUT: m_valid=1 and m_data=result. On m_ready, go to IDLE.
- Return path: each mem_en pushes {1, idx} into the return pipeline. When a stage exits valid, mem_rdata is written into result slot idx.
- Frames do not overlap. s_ready is 0 in ISSUE, DRAIN and OUT.
- m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- The result register is not cleared between frames. Every slot is rewritten each frame.
- Reset (asserted at any time, including mid-frame):
  - All outputs go to 0: s_ready, mem_en, mem_addr, m_valid, m_data, busy.
  - State returns to IDLE and return-pipeline valids clear, so in-flight returns are discarded.
  - After rst_n deasserts, s_ready=1 from the first clock edge.
- mem_addr reads 0 whenever mem_en=0.

## Timing
- Frame accepted at edge E0 (s_valid & s_ready).
- ISSUE spans cycles 1..NEURONS after E0. Neuron k is issued in cycle k+1.
- The return for neuron k is captured at the end of cycle k+1+MEM_LAT.
- m_valid rises in cycle NEURONS+MEM_LAT+1 after E0. With the defaults this is cycle 10.
- If m_ready=1 when m_valid rises, the transfer takes one cycle. s_ready returns in the following cycle.
- Minimum frame period: NEURONS+MEM_LAT+3 cycles, which is 12 with the defaults.
- No combinational path from any input to any output except s_ready/m_valid from the state register.

## Test plan
- Memory model: rdata=addr[0]^addr[FAN_IN], which is slice bit 0 XOR neuron index bit 0.
- Single frame:
  - Stimulus: defaults, s_data=64'h0101_0101_0101_0101, m_ready held 1.
  - Required: mem_addr sequence 0x001, 0x101, …, 0x701. m_valid in cycle 10 with m_data=8'b01010101. s_ready=1 in cycle 12.
- Backpressure:
  - Stimulus: same frame, m_ready=0 for 20 cycles, then 1.
  - Required: m_valid held and m_data constant throughout. s_ready stays 0 until one cycle after the transfer.
- Latency sweep:
  - Stimulus: MEM_LAT=3, frame of all zeros.
  - Required: m_valid in cycle 12 with m_data=8'b10101010. mem_en high for exactly 8 cycles.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 in cycle 5 after accept, release 2 cycles later.
  - Required: outputs 0 immediately, no stale result slot updates. The next frame yields the correct m_data.
- Back-to-back frames:
  - Stimulus: s_valid held high with two different frames, m_ready=1.
  - Required: second accept 12 cycles after the first. Both results are correct. mem_en=0 during DRAIN and OUT.
